key_filter_multi: RTL

N-channel debounced push-button front end for the VGA game control path. It replaces the single-key edge detector with a per-channel stability counter and a full press/release state machine. Per key it outputs:
- a clean level,
- one-cycle press and release strobes,
- a one-shot long-press strobe.

It sits between the board button pins and the game-logic FSMs, all in the single system clock domain.

---
 rtl/key_pkg.sv | 18 +
 rtl/key_filter_multi_if.sv | 11 +
 rtl/key_filter_ch.sv | 124 ++++++++++++
 rtl/key_filter_multi.sv | 31 +++
 4 files changed

// File: rtl/key_pkg.sv
// Shared state encodings and default 50 MHz timing for the key filter front end.
package key_pkg;

  typedef enum logic [3:0] {
    S_IDLE         = 4'b0001,
    S_PRESS_WAIT   = 4'b0010,
    S_PRESSED      = 4'b0100,
    S_RELEASE_WAIT = 4'b1000
  } key_state_t;

  localparam int CNT_DEBOUNCE_DEF = 500_000;     // 10 ms at 50 MHz
  localparam int CNT_LONG_DEF     = 50_000_000;  // 1 s at 50 MHz

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/key_filter_multi_if.sv
// Button pins in, debounced level and event strobes out, one bit per key.
interface key_filter_multi_if #(parameter int N_KEYS = 4);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] long_pulse;

  modport master (output key_in, input key_level, press_pulse, release_pulse, long_pulse);
  modport slave  (input key_in, output key_level, press_pulse, release_pulse, long_pulse);
endinterface

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchroniser, press/release debounce FSM, long-press timer.
module key_filter_ch
  import key_pkg::*;
#(
  parameter int CNT_DEBOUNCE = CNT_DEBOUNCE_DEF,
  parameter int CNT_LONG     = CNT_LONG_DEF,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int          CW      = cnt_width(CNT_DEBOUNCE, CNT_LONG);
  localparam bit          LONG_EN = (CNT_LONG != 0);
  localparam logic [CW-1:0] DEB_M1  = CW'(CNT_DEBOUNCE - 1);
  localparam logic [CW-1:0] LONG_M1 = CW'(LONG_EN ? CNT_LONG - 1 : 0);

  logic          s1, s2, p;
  key_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          long_flag, long_flag_n, long_flag_q;
  logic          held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= ACTIVE_LOW;
      s2 <= ACTIVE_LOW;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

  assign p = s2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      long_flag <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      long_flag <= long_flag_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    long_flag_n = long_flag;
    unique case (state)
      S_IDLE: begin
        if (p) begin
          state_n = S_PRESS_WAIT;
          cnt_n   = CW'(1);
        end
      end
      S_PRESS_WAIT: begin
        if (!p) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == DEB_M1) begin
          state_n = S_PRESSED;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_PRESSED: begin
        if (!p) begin
          state_n = S_RELEASE_WAIT;
          cnt_n   = CW'(1);
        end else if (LONG_EN && !long_flag) begin
          // counter parks at LONG_M1 once the flag is set, so it never wraps
          if (cnt == LONG_M1) long_flag_n = 1'b1;
          else                cnt_n       = cnt + CW'(1);
        end
      end
      S_RELEASE_WAIT: begin
        if (p) begin
          state_n = S_PRESSED;
          cnt_n   = '0;
        end else if (cnt == DEB_M1) begin
          state_n     = S_IDLE;
          cnt_n       = '0;
          long_flag_n = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n     = S_IDLE;
        cnt_n       = '0;
        long_flag_n = 1'b0;
      end
    endcase
  end

  // Output stage lags the FSM by one cycle; strobes are edges of the held/long state.
  assign held = (state == S_PRESSED) || (state == S_RELEASE_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      long_flag_q   <= 1'b0;
    end else begin
      level         <= held;
      press_pulse   <= held & ~level;
      release_pulse <= ~held & level;
      long_flag_q   <= long_flag;
      long_pulse    <= long_flag & ~long_flag_q;
    end
  end

endmodule

// File: rtl/key_filter_multi.sv
// N independent debounced key channels for the game control path.
module key_filter_multi
  import key_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int CNT_DEBOUNCE = CNT_DEBOUNCE_DEF,
  parameter int CNT_LONG     = CNT_LONG_DEF,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  key_filter_multi_if.slave bus
);

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    key_filter_ch #(
      .CNT_DEBOUNCE (CNT_DEBOUNCE),
      .CNT_LONG     (CNT_LONG),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .key           (bus.key_in[gi]),
      .level         (bus.key_level[gi]),
      .press_pulse   (bus.press_pulse[gi]),
      .release_pulse (bus.release_pulse[gi]),
      .long_pulse    (bus.long_pulse[gi])
    );
  end

endmodule
